// File: rtl/vga_pixel_scanner.sv
// VGA raster-timing initiator: divides the system clock to the pixel rate, scans
// p_row/p_col over the frame and registers blanked rgb plus active-low syncs.
module vga_pixel_scanner #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] color_data,
    output logic [9:0]  p_row,
    output logic [9:0]  p_col,
    output logic        video_on,
    output logic        pixel_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             line_end;
    logic             frame_end;
    logic             in_hsync;
    logic             in_vsync;

    always_comb begin
        div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = (v_cnt == V_LAST);
    assign in_hsync  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign in_vsync  = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign video_on  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign p_col     = h_cnt;
    assign p_row     = v_cnt;

    // The strobe is registered from div_next so it is high exactly while
    // div_cnt sits at its last value, i.e. on the final clk of each pixel.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of the order of always_ff blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            pixel_tick <= (div_next == DIV_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_tick) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Output stage sees the pre-advance position, so pins trail p_row/p_col
    // by one pixel while rgb and both syncs stay aligned with each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_tick && line_end && frame_end;
            if (pixel_tick) begin
                rgb   <= video_on ? color_data : 12'h000;
                hsync <= ~in_hsync;
                vsync <= ~in_vsync;
            end
        end
    end

endmodule
